// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and helpers for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_MULS = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_DIVS = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  // Magnitude of a zero-extended two's-complement value (any width up to 64);
  // callers truncate the result back to their own width.
  function automatic logic [63:0] abs_val(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             fin,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc, sreg, opd;
  logic [CW-1:0]    cnt;
  logic             busy, mode_q;
  logic [WIDTH:0]   madd, dsh, ddiff;
  logic             qbit;

  assign fin    = busy && (cnt == CW'(WIDTH - 1));
  assign res_lo = sreg;
  assign res_hi = acc;

  // acc is the product high half (mul) or the partial remainder (div)
  always_comb begin
    madd  = {1'b0, acc} + (sreg[0] ? {1'b0, opd} : '0);
    dsh   = {acc, sreg[WIDTH-1]};
    ddiff = dsh - {1'b0, opd};
    qbit  = !ddiff[WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      sreg   <= '0;
      opd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      mode_q <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      sreg   <= opa;
      opd    <= opb;
      cnt    <= '0;
      busy   <= 1'b1;
      mode_q <= mode_div;
    end else if (busy) begin
      if (mode_q) begin
        acc  <= qbit ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0];
        sreg <= {sreg[WIDTH-2:0], qbit};
      end else begin
        acc  <= madd[WIDTH:1];
        sreg <= {madd[0], sreg[WIDTH-1:1]};
      end
      cnt <= cnt + CW'(1);
      if (fin) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops plus iterative mul/div.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic             accept, is_mul, is_div, is_signed, b_zero, go_iter;
  logic             sub_op, add_ovf;
  logic [WIDTH-1:0] bx, sum, a_mag, b_mag;
  logic [WIDTH-1:0] sc_y, sc_hi, fx_y, fx_hi;
  logic             sc_ovf, sc_dbz;
  logic             div_q, neg_q, rneg_q, ovf_q;
  logic             eng_fin;
  logic [WIDTH-1:0] eng_lo, eng_hi;
  logic [2*WIDTH-1:0] prod;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign zero      = (y == '0);
  assign accept    = in_valid && in_ready;

  assign is_mul    = MUL_EN && ((op == OP_MULU) || (op == OP_MULS));
  assign is_div    = DIV_EN && ((op == OP_DIVU) || (op == OP_DIVS));
  assign is_signed = op[0];
  assign b_zero    = (b == '0);
  // divide by zero bypasses the engine and completes like a single-cycle op
  assign go_iter   = accept && (is_mul || (is_div && !b_zero));

  assign a_mag = (is_signed && a[WIDTH-1]) ? WIDTH'(abs_val(64'(a), 1'b1)) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? WIDTH'(abs_val(64'(b), 1'b1)) : b;

  assign sub_op  = (op == OP_SUB) || (op == OP_SLT);
  assign bx      = sub_op ? ~b : b;
  assign sum     = a + bx + WIDTH'(sub_op);
  assign add_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sc_y   = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    case (op)
      OP_AND:  sc_y = a & b;
      OP_OR:   sc_y = a | b;
      OP_ANDN: sc_y = a & ~b;
      OP_ORN:  sc_y = a | ~b;
      OP_ADD, OP_SUB: begin
        sc_y   = sum;
        sc_ovf = add_ovf;
      end
      OP_SLT:  sc_y = WIDTH'(sum[WIDTH-1] ^ add_ovf);
      OP_DIVU, OP_DIVS: begin
        if (DIV_EN && b_zero) begin
          sc_y   = '1;
          sc_hi  = a;
          sc_dbz = 1'b1;
        end
      end
      default: ;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (go_iter),
    .mode_div (is_div),
    .opa      (a_mag),
    .opb      (b_mag),
    .fin      (eng_fin),
    .res_lo   (eng_lo),
    .res_hi   (eng_hi)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (go_iter) begin
      div_q  <= is_div;
      neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q <= is_signed && a[WIDTH-1];
      ovf_q  <= is_div && is_signed && (a == MIN_V) && (b == '1);
    end
  end

  // quotient/product take the XOR of operand signs; remainder follows the dividend
  always_comb begin
    fx_y  = eng_lo;
    fx_hi = eng_hi;
    prod  = {eng_hi, eng_lo};
    if (div_q) begin
      if (neg_q)  fx_y  = -eng_lo;
      if (rneg_q) fx_hi = -eng_hi;
    end else begin
      if (neg_q) prod = -prod;
      fx_y  = prod[WIDTH-1:0];
      fx_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = go_iter ? BUSY : DONE;
      BUSY: if (eng_fin) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = go_iter ? BUSY : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y           <= '0;
      hi          <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == FIX) begin
      y           <= fx_y;
      hi          <= fx_hi;
      overflow    <= ovf_q;
      div_by_zero <= 1'b0;
    end else if (accept && !go_iter) begin
      y           <= sc_y;
      hi          <= sc_hi;
      overflow    <= sc_ovf;
      div_by_zero <= sc_dbz;
    end
  end

endmodule
